// File: rtl/io_output_devices.sv
// io_output_devices: memory-mapped HEX/LEDR/LEDG output registers with
// readback, per-digit blanking and a millisecond-based blink engine.
//
// state | meaning
// ------+----------------------------------------------
// SHOW  | digits visible (unless individually blanked)
// HIDE  | all digits blanked by the blink engine
module io_output_devices #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ABUS,
    inout  wire  [31:0] DBUS,
    input  logic        we,
    output logic [9:0]  LEDR,
    output logic [7:0]  LEDG,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
    localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
    localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
    localparam logic [31:0] ADDR_DCTRL = 32'hF000_000C;

    localparam int              PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic {SHOW = 1'b0, HIDE = 1'b1} phase_e;

    logic [15:0]      hexReg;
    logic [9:0]       ledrReg;
    logic [7:0]       ledgReg;
    logic             blinkEn;
    logic [3:0]       blankMask;
    logic [15:0]      halfPeriod;
    logic [PRE_W-1:0] prescale;
    logic [15:0]      msCount;
    phase_e           phase, phaseNext;

    logic        wrHex, wrLedr, wrLedg, wrDctrl, restart;
    logic        tick, terminal;
    logic [15:0] hpLast;
    logic        readHit;
    logic [31:0] readData;
    logic        hideAll;

    assign wrHex   = we && (ABUS == ADDR_HEX);
    assign wrLedr  = we && (ABUS == ADDR_LEDR);
    assign wrLedg  = we && (ABUS == ADDR_LEDG);
    assign wrDctrl = we && (ABUS == ADDR_DCTRL);
    // Changing what is shown or how it blinks restarts the blink from SHOW.
    assign restart = wrHex || wrDctrl;

    // A half period of 0 behaves as 1 ms, so the terminal count is then 0.
    assign hpLast   = (halfPeriod == 16'd0) ? 16'd0 : halfPeriod - 16'd1;
    assign tick     = blinkEn && (prescale == PRE_LAST);
    assign terminal = tick && (msCount == hpLast);

    // Register file: stores from the bus, reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hexReg     <= '0;
            ledrReg    <= '0;
            ledgReg    <= '0;
            blinkEn    <= 1'b0;
            blankMask  <= '0;
            halfPeriod <= '0;
        end else begin
            if (wrHex)  hexReg  <= DBUS[15:0];
            if (wrLedr) ledrReg <= DBUS[9:0];
            if (wrLedg) ledgReg <= DBUS[7:0];
            if (wrDctrl) begin
                blinkEn    <= DBUS[0];
                blankMask  <= DBUS[7:4];
                halfPeriod <= DBUS[31:16];
            end
        end
    end

    // Prescaler and ms counter; held at zero while blinking is off or on restart.
    always_ff @(posedge clk) begin
        if (!rst || restart || !blinkEn) begin
            prescale <= '0;
            msCount  <= '0;
        end else begin
            prescale <= tick ? '0 : prescale + 1'b1;
            if (terminal)  msCount <= '0;
            else if (tick) msCount <= msCount + 16'd1;
        end
    end

    // Blink phase state register.
    always_ff @(posedge clk) begin
        if (!rst) phase <= SHOW;
        else      phase <= phaseNext;
    end

    // Blink phase next-state: restart wins over a coincident terminal tick.
    always_comb begin
        phaseNext = phase;
        if (restart || !blinkEn) begin
            phaseNext = SHOW;
        end else if (terminal) begin
            phaseNext = (phase == SHOW) ? HIDE : SHOW;
        end
    end

    function automatic logic [6:0] segDecode(input logic [3:0] d);
        case (d)
            4'h0: segDecode = 7'h40;
            4'h1: segDecode = 7'h79;
            4'h2: segDecode = 7'h24;
            4'h3: segDecode = 7'h30;
            4'h4: segDecode = 7'h19;
            4'h5: segDecode = 7'h12;
            4'h6: segDecode = 7'h02;
            4'h7: segDecode = 7'h78;
            4'h8: segDecode = 7'h00;
            4'h9: segDecode = 7'h10;
            4'hA: segDecode = 7'h08;
            4'hB: segDecode = 7'h03;
            4'hC: segDecode = 7'h46;
            4'hD: segDecode = 7'h21;
            4'hE: segDecode = 7'h06;
            default: segDecode = 7'h0E;
        endcase
    endfunction

    assign hideAll = blinkEn && (phase == HIDE);
    assign HEX0 = (blankMask[0] || hideAll) ? 7'h7F : segDecode(hexReg[3:0]);
    assign HEX1 = (blankMask[1] || hideAll) ? 7'h7F : segDecode(hexReg[7:4]);
    assign HEX2 = (blankMask[2] || hideAll) ? 7'h7F : segDecode(hexReg[11:8]);
    assign HEX3 = (blankMask[3] || hideAll) ? 7'h7F : segDecode(hexReg[15:12]);
    assign LEDR = ledrReg;
    assign LEDG = ledgReg;

    // Readback mux: zero-extended register for a mapped address.
    always_comb begin
        readHit  = 1'b1;
        readData = '0;
        case (ABUS)
            ADDR_HEX:   readData = {16'd0, hexReg};
            ADDR_LEDR:  readData = {22'd0, ledrReg};
            ADDR_LEDG:  readData = {24'd0, ledgReg};
            ADDR_DCTRL: readData = {halfPeriod, 8'd0, blankMask, 3'd0, blinkEn};
            default:    readHit  = 1'b0;
        endcase
    end

    assign DBUS = (!we && readHit) ? readData : 32'bz;

endmodule

// File: doc/io_output_devices.md
# io_output_devices

Memory-mapped output peripheral for the processor's I/O address space: the write/display end of the bus that the input devices (keys, switches, timer) read from. It decodes processor stores on the address/data bus into the HEX, LEDR and LEDG board outputs, supports readback of every register, and provides per-digit blanking and a millisecond-based blink engine for the 7-segment display. It sits beside the input devices inside the I/O controller, on the same ABUS/DBUS/we signals as data memory.

## Interface
- ADDR_HEX, 32'hF0000000, HEX data register (4 hex digits, bits 15:0)
- ADDR_LEDR, 32'hF0000004, red LED register (bits 9:0)
- ADDR_LEDG, 32'hF0000008, green LED register (bits 7:0)
- ADDR_DCTRL, 32'hF000000C, display control register
- TICK_DIV, 50000, clk cycles per 1 ms tick (must be ≥2)
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  reset; synchronous and active-low (0 = reset, sampled on posedge clk)
- ABUS  in  32  bus address
- DBUS  inout  32  bus data; the block drives it only on a readback hit
- we  in  1  store strobe
- LEDR  out  10  = LEDR register
- LEDG  out  8  = LEDG register
- HEX0..HEX3  out  7 each  active-low segments, bit0 = a … bit6 = g; HEX0 is the least-significant digit

## Operation
- Write: on a posedge where we=1 and ABUS equals a mapped address, the register loads the low bits of DBUS. Unmapped addresses are ignored.
- DCTRL fields:
  - bit0: BLINK_EN
  - bits 7:4: BLANK mask (bit 4+n blanks HEXn)
  - bits 31:16: HALF_PERIOD in ms; 0 is treated as 1
  - Bits 15:8 and 3:1 are not stored and read as 0.
- Readback: when we=0 and ABUS hits a mapped address, DBUS is driven combinationally with the zero-extended register value. Otherwise DBUS=32'bz. The block never drives DBUS when we=1.
- Segment encoding, digits 0–F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit). Blank = 7'h7F.
- HEXn shows blank if BLANK[n]=1 or (BLINK_EN=1 and phase=HIDE); otherwise it shows the decoded digit HEX[4n+3:4n].
- Blink engine:
  - Prescaler counts 0..TICK_DIV-1 and wraps; it asserts an internal tick on the count TICK_DIV-1.
  - ms counter increments on each tick. On a tick where the ms counter = HALF_PERIOD-1, phase toggles (SHOW↔HIDE) and the ms counter clears.
  - FSM states: SHOW, HIDE. SHOW→HIDE and HIDE→SHOW only on that terminal tick.
  - When BLINK_EN=0: phase is forced to SHOW and both counters are held at 0.
- Restart: any write to HEX or DCTRL sets phase=SHOW and clears both counters in the same edge. The write has priority over a coincident toggle.

## Timing
- Reset values: HEX=0, LEDR=0, LEDG=0, DCTRL=0, phase=SHOW, counters=0. Outputs after reset: HEX0..3=7'h40 (display "0000"), LEDR=0, LEDG=0, DBUS=Z.
- rst has priority over writes and ticks. Reset mid-blink returns phase to SHOW on that edge.
- Write latency: a store accepted at edge k is visible on LEDR/LEDG/HEXn and on readback immediately after edge k. The outputs are combinational from the registers, with no extra register stage.
- Readback is combinational: DBUS is valid in the same cycle that ABUS/we present the read.
- Blink half-period = HALF_PERIOD × TICK_DIV clk cycles exactly, measured from the restart edge. The first toggle occurs HALF_PERIOD×TICK_DIV cycles after a DCTRL/HEX write.
- HALF_PERIOD=0xFFFF must not overflow: the ms counter is 16 bits and wraps only through the terminal compare.

## Test plan
Bench uses TICK_DIV=4.
1. Reset, then idle → HEX0..3=7'h40, LEDR=0, LEDG=0, DBUS=Z; a read of each mapped address returns 0.
2. Store 0x0000ABCD to ADDR_HEX → after the edge HEX3..0 = 08,03,46,21; a read of ADDR_HEX returns 0x0000ABCD. Store 0x3FF to ADDR_LEDR and 0xA5 to ADDR_LEDG → LEDR=10'h3FF, LEDG=8'hA5.
3. Store 0x000200A1 to DCTRL (HALF_PERIOD=2, BLANK=0xA, BLINK_EN=1) → HEX1 and HEX3 = 7'h7F at all times; HEX0 and HEX2 blank after exactly 8 cycles and show again 8 cycles later. A DCTRL read returns 0x000200A1.
4. During HIDE, store to ADDR_HEX on the edge of a terminal tick → phase=SHOW, the new digits are visible next cycle, and the next toggle occurs 8 cycles later.
5. Assert rst=0 for one edge mid-HIDE → all registers 0, display "0000", phase SHOW. Store to 0xF0000010 (unmapped) with we=1 → no register changes; DBUS is not driven on a read of 0xF0000010.
6. DCTRL with HALF_PERIOD=0, BLINK_EN=1 → toggles every 4 cycles, behaving as HALF_PERIOD=1.
